// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the multiply/divide unit.
//   OP_*    : 5-bit ALU control codes, shared with the ALU decoder.
//   state_e : sequencer state (IDLE, RUN, FIX).
package muldiv_pkg;

    localparam logic [4:0] OP_MULTU = 5'b00111;
    localparam logic [4:0] OP_MULT  = 5'b01000;
    localparam logic [4:0] OP_DIV   = 5'b01111;
    localparam logic [4:0] OP_DIVU  = 5'b10000;
    localparam logic [4:0] OP_MTHI  = 5'b10001;
    localparam logic [4:0] OP_MTLO  = 5'b10010;
    localparam logic [4:0] OP_MFHI  = 5'b11010;
    localparam logic [4:0] OP_MFLO  = 5'b11011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: radix-2 iterative engine on unsigned magnitudes.
//   clk_i, reset_i : clock, synchronous active-high reset
//   load_i         : capture operands, clear accumulator and counter
//   en_i           : perform one iteration step
//   div_mode_i     : 1 = restoring divide, 0 = shift-add multiply (latched on load)
//   a_mag_i        : multiplier / dividend magnitude
//   b_mag_i        : multiplicand / divisor magnitude (WIDTH+1 bits)
//   last_c_o       : current step is the final (WIDTH-th) iteration
//   hi_o, lo_o     : product high/low, or remainder/quotient
module muldiv_iter_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic             div_mode_i,
    input  logic [WIDTH-1:0] a_mag_i,
    input  logic [WIDTH:0]   b_mag_i,
    output logic             last_c_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned XW    = WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [XW-1:0]    hi_q, hi_d;
    logic [XW-1:0]    mcand_q;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q;
    logic             mode_q;

    logic [XW:0]      sum_c;
    logic [XW:0]      shl_c;
    logic [XW:0]      diff_c;
    logic             ge_c;

    // One iteration: multiply shifts the accumulator right, divide shifts left.
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        sum_c  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        shl_c  = {hi_q, lo_q[WIDTH-1]};
        diff_c = shl_c - {1'b0, mcand_q};
        // No borrow means the trial subtraction fits and the quotient bit is 1.
        ge_c   = ~diff_c[XW];
        if (mode_q) begin
            hi_d = ge_c ? diff_c[XW-1:0] : shl_c[XW-1:0];
            lo_d = {lo_q[WIDTH-2:0], ge_c};
        end else begin
            hi_d = sum_c[XW:1];
            lo_d = {sum_c[0], lo_q[WIDTH-1:1]};
        end
    end

    // Accumulator, operand and counter registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else if (load_i) begin
            hi_q    <= '0;
            lo_q    <= a_mag_i;
            mcand_q <= b_mag_i;
            cnt_q   <= '0;
            mode_q  <= div_mode_i;
        end else if (en_i) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    assign last_c_o = (cnt_q == CNT_W'(WIDTH - 1));
    assign hi_o     = hi_q[WIDTH-1:0];
    assign lo_o     = lo_q;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide engine with architectural HI/LO.
//   clk, reset : clock, synchronous active-high reset
//   start, op  : request and 5-bit ALU code (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   a, b       : rs / rt operands
//   busy       : multiply/divide in flight, requests ignored
//   done       : one-cycle pulse when new HI/LO become visible
//   hi, lo     : HI / LO registers
// Optional: define MULDIV_FAST_MULT_EN for single-cycle MULT/MULTU.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned XW = WIDTH + 1;

    state_e           state_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             div_q, neg_q, rneg_q, dz_q;

    logic             is_mul_c, is_div_c, is_signed_c;
    logic             accept_c, go_iter_c;
    logic [XW-1:0]    a_ext_c, b_ext_c, a_mag_c, b_mag_c;
    logic [2*WIDTH-1:0] prod_c, prod_fix_c;
    logic [WIDTH-1:0] quo_fix_c, rem_fix_c;
    logic             unused_a_mag_msb_c;

    logic             core_last_c;
    logic [WIDTH-1:0] core_hi, core_lo;

    // Decode, operand magnitudes and result sign fix-up.
    always_comb begin
        is_mul_c    = (op == OP_MULT) || (op == OP_MULTU);
        is_div_c    = (op == OP_DIV)  || (op == OP_DIVU);
        is_signed_c = (op == OP_MULT) || (op == OP_DIV);
        accept_c    = start && !busy_q && (state_q == IDLE);
`ifdef MULDIV_FAST_MULT_EN
        go_iter_c   = accept_c && is_div_c;
`else
        go_iter_c   = accept_c && (is_mul_c || is_div_c);
`endif
        // One extra bit keeps the magnitude of the most negative operand exact.
        a_ext_c = is_signed_c ? {a[WIDTH-1], a} : {1'b0, a};
        b_ext_c = is_signed_c ? {b[WIDTH-1], b} : {1'b0, b};
        a_mag_c = a_ext_c[WIDTH] ? XW'(-a_ext_c) : a_ext_c;
        b_mag_c = b_ext_c[WIDTH] ? XW'(-b_ext_c) : b_ext_c;
        // A magnitude never exceeds 2^WIDTH-1, so the dividend/multiplier MSB is always zero.
        unused_a_mag_msb_c = a_mag_c[WIDTH];

        prod_c     = {core_hi, core_lo};
        prod_fix_c = neg_q ? -prod_c : prod_c;
        // Divide by zero forces an all-ones quotient; the remainder path already yields a.
        quo_fix_c  = dz_q ? '1 : (neg_q ? -core_lo : core_lo);
        rem_fix_c  = rneg_q ? -core_hi : core_hi;
    end

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod_c;

    // Full-width product; the low 2*WIDTH bits of extended operands give the signed result.
    always_comb begin
        fast_prod_c = is_signed_c
            ? ({{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b})
            : ({{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b});
    end
`endif

    muldiv_iter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (go_iter_c),
        .en_i       (state_q == RUN),
        .div_mode_i (is_div_c),
        .a_mag_i    (a_mag_c[WIDTH-1:0]),
        .b_mag_i    (b_mag_c),
        .last_c_o   (core_last_c),
        .hi_o       (core_hi),
        .lo_o       (core_lo)
    );

    // Sequencer, handshake and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        if (op == OP_MTHI) hi_q <= a;
                        if (op == OP_MTLO) lo_q <= a;
`ifdef MULDIV_FAST_MULT_EN
                        if (is_mul_c) begin
                            hi_q   <= fast_prod_c[2*WIDTH-1:WIDTH];
                            lo_q   <= fast_prod_c[WIDTH-1:0];
                            done_q <= 1'b1;
                        end
`endif
                        if (go_iter_c) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            div_q   <= is_div_c;
                            neg_q   <= a_ext_c[WIDTH] ^ b_ext_c[WIDTH];
                            rneg_q  <= a_ext_c[WIDTH];
                            dz_q    <= (b == '0);
                        end
                    end
                end
                RUN: begin
                    if (core_last_c) state_q <= FIX;
                end
                FIX: begin
                    if (div_q) begin
                        hi_q <= rem_fix_c;
                        lo_q <= quo_fix_c;
                    end else begin
                        hi_q <= prod_fix_c[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix_c[WIDTH-1:0];
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (WIDTH = 32).
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam logic [4:0] T_MULTU = 5'b00111;
    localparam logic [4:0] T_MULT  = 5'b01000;
    localparam logic [4:0] T_DIV   = 5'b01111;
    localparam logic [4:0] T_DIVU  = 5'b10000;
    localparam logic [4:0] T_MTHI  = 5'b10001;
    localparam logic [4:0] T_MTLO  = 5'b10010;
    localparam logic [4:0] T_MFHI  = 5'b11010;

    localparam int DIV_LAT  = 34;
    localparam int DIV_BUSY = 33;
`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT  = 1;
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_LAT  = 34;
    localparam int MUL_BUSY = 33;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk, reset, start, busy, done;
    logic [4:0]  op;
    logic [31:0] a, b, hi, lo;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; holds the request across one rising edge.
    task automatic drive(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 5'd0; a = '0; b = '0;
    endtask

    task automatic push(input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        e.hi = eh;
        e.lo = el;
        sb.push_back(e);
    endtask

    // Waits for done (bounded), then pops the scoreboard and checks results and timing.
    task automatic wait_done(input string tag, input int start_n, input int exp_lat, input int exp_busy);
        int   n    = start_n;
        int   bcnt = 0;
        exp_t e;
        while (done !== 1'b1 && n < 200) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 64'(done), 64'(1));
        if (sb.size() > 0) e = sb.pop_front();
        else begin e.hi = 'x; e.lo = 'x; end
        chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
        chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'(0));
        if (exp_busy >= 0) chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_busy));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        clk = 1'b0; reset = 1'b1; start = 1'b0; op = 5'd0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));

        push(32'hFFFF_FFFE, 32'h0000_0001);
        drive(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", 1, MUL_LAT, MUL_BUSY);

        push(32'hFFFF_FFFF, 32'hFFFF_FFEB);
        drive(T_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done("mult_neg", 1, MUL_LAT, -1);

        push(32'h4000_0000, 32'h0000_0000);
        drive(T_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done("mult_minmin", 1, MUL_LAT, -1);

        // MTHI arriving mid-divide must be dropped.
        push(32'hFFFF_FFFF, 32'hFFFF_FFFD);
        drive(T_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (4) @(negedge clk);
        drive(T_MTHI, 32'h0000_1234, 32'd0);
        chk("busy_mthi_hi", 64'(hi), 64'(32'h4000_0000));
        chk("busy_mthi_busy", 64'(busy), 64'(1));
        wait_done("div_neg", 6, DIV_LAT, -1);

        push(32'd7, 32'hFFFF_FFFF);
        drive(T_DIVU, 32'd7, 32'd0);
        wait_done("divu_by0", 1, DIV_LAT, DIV_BUSY);

        push(32'hFFFF_FFF9, 32'hFFFF_FFFF);
        drive(T_DIV, 32'hFFFF_FFF9, 32'd0);
        wait_done("div_by0", 1, DIV_LAT, -1);

        push(32'h0000_0000, 32'h8000_0000);
        drive(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 1, DIV_LAT, -1);

        drive(T_MTHI, 32'h0000_1234, 32'd0);
        chk("mthi_hi", 64'(hi), 64'(32'h0000_1234));
        chk("mthi_lo", 64'(lo), 64'(32'h8000_0000));
        chk("mthi_done", 64'(done), 64'(0));
        chk("mthi_busy", 64'(busy), 64'(0));

        drive(T_MTLO, 32'h0000_ABCD, 32'd0);
        chk("mtlo_lo", 64'(lo), 64'(32'h0000_ABCD));
        chk("mtlo_hi", 64'(hi), 64'(32'h0000_1234));
        chk("mtlo_done", 64'(done), 64'(0));

        drive(5'b00000, 32'hDEAD_BEEF, 32'd1);
        drive(T_MFHI, 32'hCAFE_F00D, 32'd1);
        chk("ign_hi", 64'(hi), 64'(32'h0000_1234));
        chk("ign_lo", 64'(lo), 64'(32'h0000_ABCD));
        chk("ign_busy", 64'(busy), 64'(0));
        chk("ign_done", 64'(done), 64'(0));

        // Abort a divide around its tenth iteration; its result must never appear.
        drive(T_DIVU, 32'hFFFF_FFFF, 32'd3);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_hi", 64'(hi), 64'(0));
        chk("abort_lo", 64'(lo), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_state", 64'(dut.state_q), 64'(IDLE));
        reset = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        chk("abort_no_done", 64'(dcnt), 64'(0));

        push(32'd2, 32'd14);
        drive(T_DIVU, 32'd100, 32'd7);
        wait_done("divu_100_7", 1, DIV_LAT, -1);

        // Second request issued in the done cycle of the first.
        push(32'd0, 32'd15);
        drive(T_MULTU, 32'd3, 32'd5);
        wait_done("b2b_mul", 1, MUL_LAT, -1);
        push(32'd1, 32'd2);
        drive(T_DIVU, 32'd9, 32'd4);
        wait_done("b2b_div", 1, DIV_LAT, -1);

        repeat (2) @(negedge clk);
        chk("end_done_low", 64'(done), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
